// File: rtl/decode_hazard_if.sv
// Decode-phase handshake bundle between the miinst queue head / decode phase
// and the hazard scheduler.
interface decode_hazard_if #(
    parameter int REG_W       = 5,
    parameter int POST_DEC_LD = 3
);
    logic                   dec_valid;
    logic [REG_W-1:0]       dec_d;
    logic [REG_W-1:0]       dec_s;
    logic [REG_W-1:0]       dec_t;
    logic                   dec_wr;
    logic                   dec_load;
    logic                   dec_mc;
    logic                   mc_done;
    logic                   flush;
    logic                   stall;
    logic                   issue;
    logic [POST_DEC_LD-1:0] fwd_d;
    logic [POST_DEC_LD-1:0] fwd_s;
    logic [POST_DEC_LD-1:0] fwd_t;
    logic [31:0]            stall_cnt;

    modport master (
        output dec_valid, dec_d, dec_s, dec_t, dec_wr, dec_load, dec_mc, mc_done, flush,
        input  stall, issue, fwd_d, fwd_s, fwd_t, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_d, dec_s, dec_t, dec_wr, dec_load, dec_mc, mc_done, flush,
        output stall, issue, fwd_d, fwd_s, fwd_t, stall_cnt
    );
endinterface

// File: rtl/decode_hazard_scheduler.sv
// Decode-phase scoreboard: operand bypass selects, load-use and multi-cycle interlock.
// Optional stall-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module decode_hazard_scheduler #(
    parameter int POST_DEC_LD = 3,
    parameter int REG_W       = 5,
    parameter int RIP_IDX     = 16,
    parameter int LOAD_RDY    = 1
) (
    input logic            clk,
    input logic            rst,
    decode_hazard_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [REG_W-1:0]       RIP     = REG_W'(RIP_IDX);
    localparam logic [POST_DEC_LD-1:0] LD_LATE = POST_DEC_LD'((1 << LOAD_RDY) - 1);

    logic [0:0]             state_q, state_d;
    logic [POST_DEC_LD-1:0] vld_q, vld_d;
    logic [POST_DEC_LD-1:0] wr_q, wr_d;
    logic [POST_DEC_LD-1:0] ld_q, ld_d;
    logic [REG_W-1:0]       dst_q [POST_DEC_LD];
    logic [REG_W-1:0]       dst_d [POST_DEC_LD];

    logic [POST_DEC_LD-1:0] m_d, m_s, m_t;
    logic [POST_DEC_LD-1:0] y_d, y_s, y_t;
    logic                   load_use;
    logic                   stall_w;
    logic                   issue_w;

    function automatic logic [POST_DEC_LD-1:0] youngest(input logic [POST_DEC_LD-1:0] m);
        return m & (~m + POST_DEC_LD'(1));
    endfunction

    // match: stage comparison against head operands
    always_comb begin
        m_d = '0;
        m_s = '0;
        m_t = '0;
        for (int k = 0; k < POST_DEC_LD; k++) begin
            m_d[k] = vld_q[k] & wr_q[k] & (dst_q[k] == bus.dec_d) & (bus.dec_d != RIP);
            m_s[k] = vld_q[k] & wr_q[k] & (dst_q[k] == bus.dec_s) & (bus.dec_s != RIP);
            m_t[k] = vld_q[k] & wr_q[k] & (dst_q[k] == bus.dec_t) & (bus.dec_t != RIP);
        end
        y_d = youngest(m_d);
        y_s = youngest(m_s);
        y_t = youngest(m_t);
    end

    // A producing load still short of its data stage cannot be bypassed yet.
    assign load_use = |((y_d | y_s | y_t) & ld_q & LD_LATE);
    assign stall_w  = ~rst & bus.dec_valid & ~bus.flush & ((state_q == ST_BUSY) | load_use);
    assign issue_w  = ~rst & bus.dec_valid & ~bus.flush & ~stall_w;

    assign bus.stall = stall_w;
    assign bus.issue = issue_w;
    assign bus.fwd_d = y_d;
    assign bus.fwd_s = y_s;
    assign bus.fwd_t = y_t;

    // next state: stage shift and multi-cycle FSM
    always_comb begin
        vld_d    = '0;
        wr_d     = '0;
        ld_d     = '0;
        vld_d[0] = issue_w;
        wr_d[0]  = bus.dec_wr;
        ld_d[0]  = bus.dec_load;
        dst_d[0] = bus.dec_d;
        for (int k = 1; k < POST_DEC_LD; k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
            ld_d[k]  = ld_q[k-1];
            dst_d[k] = dst_q[k-1];
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue_w && bus.dec_mc) state_d = ST_BUSY;
            ST_BUSY: if (bus.mc_done)           state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            vld_q   <= vld_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q <= wr_d;
        ld_q <= ld_d;
        for (int k = 0; k < POST_DEC_LD; k++) begin
            dst_q[k] <= dst_d[k];
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_hazard_scheduler.sv
// Randomized scoreboard bench for decode_hazard_scheduler against an in-bench
// model of the in-flight history (queue of issued/bubble slots, youngest first).
module tb_decode_hazard_scheduler;
    localparam int NST = 3;
    localparam int LRDY = 1;
    localparam bit [4:0] RIP = 5'd16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_hazard_if #(.REG_W(5), .POST_DEC_LD(NST)) bus ();
    decode_hazard_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {bit v; bit w; bit l; bit [4:0] d;} ent_t;
    typedef struct {bit stall; bit issue; bit [2:0] fd; bit [2:0] fs; bit [2:0] ft; bit [31:0] cnt;} exp_t;

    ent_t      hist[$];
    exp_t      sb[$];
    bit        busy = 1'b0;
    bit [31:0] cnt  = 32'd0;
    int        n_cmp = 0;
    int        n_bad = 0;

    function automatic bit [2:0] find_src(input bit [4:0] r, output bit early_ld);
        early_ld = 1'b0;
        if (r == RIP) return 3'b000;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].v && hist[k].w && hist[k].d == r) begin
                early_ld = hist[k].l && (k < LRDY);
                return 3'(1 << k);
            end
        end
        return 3'b000;
    endfunction

    task automatic step(input bit r, input bit v, input bit [4:0] d, input bit [4:0] s,
                        input bit [4:0] t, input bit w, input bit l, input bit mc,
                        input bit done, input bit fl);
        exp_t e;
        ent_t n;
        bit   ed, es, et;
        rst = r;
        bus.dec_valid = v; bus.dec_d = d; bus.dec_s = s; bus.dec_t = t;
        bus.dec_wr = w; bus.dec_load = l; bus.dec_mc = mc; bus.mc_done = done; bus.flush = fl;
        e.fd = find_src(d, ed);
        e.fs = find_src(s, es);
        e.ft = find_src(t, et);
        e.stall = !r && v && !fl && (busy || ed || es || et);
        e.issue = !r && v && !fl && !e.stall;
`ifdef HAZ_STALL_CNT_EN
        e.cnt = cnt;
`else
        e.cnt = 32'd0;
`endif
        sb.push_back(e);
        if (r) begin
            hist.delete();
            busy = 1'b0;
            cnt  = 32'd0;
        end else begin
            if (e.stall && cnt != 32'hFFFF_FFFF) cnt = cnt + 32'd1;
            if (busy) begin
                if (done) busy = 1'b0;
            end else if (e.issue && mc) begin
                busy = 1'b1;
            end
            n.v = e.issue; n.w = w; n.l = l; n.d = d;
            hist.push_front(n);
            if (hist.size() > NST) void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall", 32'(bus.stall), 32'(e.stall));
            check("issue", 32'(bus.issue), 32'(e.issue));
            check("fwd_d", 32'(bus.fwd_d), 32'(e.fd));
            check("fwd_s", 32'(bus.fwd_s), 32'(e.fs));
            check("fwd_t", 32'(bus.fwd_t), 32'(e.ft));
            check("stall_cnt", bus.stall_cnt, e.cnt);
        end
    end

    function automatic bit [4:0] rreg();
        int unsigned x;
        x = $urandom_range(0, 4);
        return (x == 4) ? RIP : 5'(x);
    endfunction

    initial begin
        rst = 1'b1;
        bus.dec_valid = 1'b1; bus.dec_d = '0; bus.dec_s = '0; bus.dec_t = '0;
        bus.dec_wr = 1'b0; bus.dec_load = 1'b0; bus.dec_mc = 1'b0; bus.mc_done = 1'b0; bus.flush = 1'b0;
        @(posedge clk);
        #1;
        // reset held with a valid head
        step(1, 1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0);
        step(1, 1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0);
        // ALU writer r3, then readers of r3 at stage 0 and stage 1
        step(0, 1, 5'd3, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        step(0, 1, 5'd7, 5'd3, 5'd1, 0, 0, 0, 0, 0);
        step(0, 1, 5'd8, 5'd3, 5'd1, 0, 0, 0, 0, 0);
        // load-use on r5
        step(0, 1, 5'd5, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        step(0, 1, 5'd9, 5'd1, 5'd5, 0, 0, 0, 0, 0);
        step(0, 1, 5'd9, 5'd1, 5'd5, 0, 0, 0, 0, 0);
        // two writers of r2, youngest wins
        step(0, 1, 5'd2, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        step(0, 1, 5'd2, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        step(0, 1, 5'd2, 5'd10, 5'd11, 0, 0, 0, 0, 0);
        // multi-cycle op, result returns in sixth busy cycle
        step(0, 1, 5'd12, 5'd0, 5'd0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 5'd13, 5'd0, 5'd0, 1, 0, 0, (i == 5), 0);
        step(0, 1, 5'd13, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        // RIP index never forwards; flush during a load-use stall
        step(0, 1, RIP, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        step(0, 1, 5'd14, RIP, 5'd0, 0, 0, 0, 0, 0);
        step(0, 1, 5'd6, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        step(0, 1, 5'd15, 5'd0, 5'd6, 0, 0, 0, 0, 1);
        step(0, 1, 5'd15, 5'd0, 5'd6, 0, 0, 0, 0, 0);
        // mc issue then flush while busy, with a late rst mid-busy
        step(0, 1, 5'd1, 5'd0, 5'd0, 1, 0, 1, 0, 0);
        step(0, 1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 1);
        step(0, 1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        step(1, 1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        step(0, 1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 1, 0);
        step(0, 1, 5'd1, 5'd1, 5'd0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80),
                 rreg(), rreg(), rreg(),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 8));
        end

        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
